// File: rtl/btn_conditioner.sv
// Button/switch input conditioner: 2-FF synchronizers, per-button debounce,
// one-cycle press pulses and a switch snapshot. Optional macro BTN_ONEHOT_PULSE_EN.
module btn_conditioner #(
  parameter int NB_INPUT_SELECT = 3,
  parameter int NB_DATA_IN      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                       clock,
  input  logic                       i_rst,
  input  logic [NB_INPUT_SELECT-1:0] i_btn,
  input  logic [NB_DATA_IN-1:0]      i_sw_data,
  output logic [NB_INPUT_SELECT-1:0] o_btn_level,
  output logic [NB_INPUT_SELECT-1:0] o_btn_pulse,
  output logic [NB_DATA_IN-1:0]      o_sw_data
);

  localparam int NB_CNT = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_CNT-1:0] CNT_ZERO = NB_CNT'(0);
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

  logic [NB_INPUT_SELECT-1:0] btn_sync1_r, btn_sync2_r;
  logic [NB_DATA_IN-1:0]      sw_sync1_r, sw_sync2_r;
  logic [NB_CNT-1:0]          cnt_r [NB_INPUT_SELECT];
  logic [NB_INPUT_SELECT-1:0] level_r, pulse_r;
  logic [NB_DATA_IN-1:0]      sw_data_r;

  logic [NB_INPUT_SELECT-1:0] flip_s, rise_s, pulse_s;
  logic                       capture_s;

  // Flip decision per button and the resulting pulse candidates
  always_comb begin
    flip_s = {NB_INPUT_SELECT{1'b0}};
    for (int i = 0; i < NB_INPUT_SELECT; i++) begin
      if ((btn_sync2_r[i] != level_r[i]) && (cnt_r[i] == CNT_LAST)) begin
        flip_s[i] = 1'b1;
      end else begin
        flip_s[i] = 1'b0;
      end
    end
    rise_s = flip_s & ~level_r;
`ifdef BTN_ONEHOT_PULSE_EN
    // Two's-complement trick isolates the lowest set bit
    pulse_s = rise_s & (~rise_s + NB_INPUT_SELECT'(1));
`else
    pulse_s = rise_s;
`endif
    capture_s = |pulse_s;
  end

  // Two-stage synchronizers for buttons and switches
  always_ff @(posedge clock) begin
    if (i_rst) begin
      btn_sync1_r <= {NB_INPUT_SELECT{1'b0}};
      btn_sync2_r <= {NB_INPUT_SELECT{1'b0}};
      sw_sync1_r  <= {NB_DATA_IN{1'b0}};
      sw_sync2_r  <= {NB_DATA_IN{1'b0}};
    end else begin
      btn_sync1_r <= i_btn;
      btn_sync2_r <= btn_sync1_r;
      sw_sync1_r  <= i_sw_data;
      sw_sync2_r  <= sw_sync1_r;
    end
  end

  // Debounce counters: count consecutive cycles of disagreement with the level
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB_INPUT_SELECT; i++) begin
      if (i_rst) begin
        cnt_r[i] <= CNT_ZERO;
      end else if (btn_sync2_r[i] == level_r[i]) begin
        cnt_r[i] <= CNT_ZERO;
      end else if (cnt_r[i] == CNT_LAST) begin
        cnt_r[i] <= CNT_ZERO;
      end else begin
        cnt_r[i] <= cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Registered level, pulse and switch snapshot
  always_ff @(posedge clock) begin
    if (i_rst) begin
      level_r   <= {NB_INPUT_SELECT{1'b0}};
      pulse_r   <= {NB_INPUT_SELECT{1'b0}};
      sw_data_r <= {NB_DATA_IN{1'b0}};
    end else begin
      level_r <= level_r ^ flip_s;
      pulse_r <= pulse_s;
      if (capture_s) begin
        sw_data_r <= sw_sync2_r;
      end else begin
        sw_data_r <= sw_data_r;
      end
    end
  end

  assign o_btn_level = level_r;
  assign o_btn_pulse = pulse_r;
  assign o_sw_data   = sw_data_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: windowed behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_btn_conditioner;

  localparam int NB = 3;
  localparam int NW = 8;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          i_rst;
  logic [NB-1:0] i_btn;
  logic [NW-1:0] i_sw_data;
  logic [NB-1:0] o_btn_level, o_btn_pulse;
  logic [NW-1:0] o_sw_data;

  int checks   = 0;
  int failures = 0;

  btn_conditioner #(.NB_INPUT_SELECT(NB), .NB_DATA_IN(NW), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .i_rst(i_rst), .i_btn(i_btn), .i_sw_data(i_sw_data),
    .o_btn_level(o_btn_level), .o_btn_pulse(o_btn_pulse), .o_sw_data(o_sw_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: raw values take two edges to reach the debouncer; a level flips once
  // the last D debouncer samples all disagree with it.
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pulse = '0;
  logic [NW-1:0] m_sw1 = '0, m_sw2 = '0, m_sw = '0;
  logic [NB-1:0] win[$];

  always @(posedge clock) begin : model
    logic [NB-1:0] flip, rise;
    logic all_diff;
    if (i_rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
      m_sw1 = '0; m_sw2 = '0; m_sw = '0;
      win.delete();
    end else begin
      win.push_back(m_s2);
      if (win.size() > D) void'(win.pop_front());
      flip = '0;
      for (int i = 0; i < NB; i++) begin
        all_diff = (win.size() == D);
        foreach (win[j]) if (win[j][i] == m_lvl[i]) all_diff = 1'b0;
        flip[i] = all_diff;
      end
      rise  = flip & ~m_lvl;
      m_lvl = m_lvl ^ flip;
`ifdef BTN_ONEHOT_PULSE_EN
      m_pulse = '0;
      for (int i = NB - 1; i >= 0; i--) begin
        if (rise[i]) begin
          m_pulse = '0;
          m_pulse[i] = 1'b1;
        end
      end
`else
      m_pulse = rise;
`endif
      if (|m_pulse) m_sw = m_sw2;
      m_s2 = m_s1; m_s1 = i_btn;
      m_sw2 = m_sw1; m_sw1 = i_sw_data;
    end
    #1;
    chk("model_level", 32'(o_btn_level), 32'(m_lvl));
    chk("model_pulse", 32'(o_btn_pulse), 32'(m_pulse));
    chk("model_sw",    32'(o_sw_data),   32'(m_sw));
  end

  task automatic drive(input logic [NB-1:0] b, input logic [NW-1:0] s);
    @(negedge clock);
    i_btn = b;
    i_sw_data = s;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Expect quiet pulse for edges 1..5 after the drive, then the given pulse at edge 6
  task automatic expect_press(input logic [NB-1:0] ep, input logic [NW-1:0] es, input string nm);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clock); #2;
      if (e < 6) chk({nm, "_early_pulse"}, 32'(o_btn_pulse), 32'd0);
      else begin
        chk({nm, "_pulse"}, 32'(o_btn_pulse), 32'(ep));
        chk({nm, "_sw"},    32'(o_sw_data),   32'(es));
      end
    end
    @(posedge clock); #2;
    chk({nm, "_pulse_one_cycle"}, 32'(o_btn_pulse), 32'd0);
  endtask

  logic [NB-1:0] a_btn [3] = '{3'b001, 3'b010, 3'b100};
  logic [NW-1:0] a_sw  [3] = '{8'h3C, 8'h0F, 8'h20};
  int hold [NB];

  initial begin
    i_rst = 1'b1; i_btn = 3'b111; i_sw_data = 8'hFF;
    // Reset with all inputs high
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #2;
      chk("rst_level", 32'(o_btn_level), 32'd0);
      chk("rst_pulse", 32'(o_btn_pulse), 32'd0);
      chk("rst_sw",    32'(o_sw_data),   32'd0);
    end
    @(negedge clock); i_rst = 1'b0;
`ifdef BTN_ONEHOT_PULSE_EN
    expect_press(3'b001, 8'hFF, "post_rst");
`else
    expect_press(3'b111, 8'hFF, "post_rst");
`endif
    chk("post_rst_level", 32'(o_btn_level), 32'h7);
    drive(3'b000, 8'h00); idle(12);

    // Clean press, hold, release
    drive(3'b001, 8'hA5);
    expect_press(3'b001, 8'hA5, "clean");
    idle(2);
    drive(3'b000, 8'h11);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clock); #2;
      chk("release_level", 32'(o_btn_level), (e < 6) ? 32'h1 : 32'h0);
      chk("release_pulse", 32'(o_btn_pulse), 32'd0);
    end
    chk("release_sw_held", 32'(o_sw_data), 32'hA5);
    idle(4);

    // Bounce on button 1, then stable press
    drive(3'b010, 8'h77); idle(1);
    drive(3'b000, 8'h77);
    drive(3'b010, 8'h77); idle(2);
    drive(3'b000, 8'h77); idle(1);
    drive(3'b010, 8'h77);
    expect_press(3'b010, 8'h77, "bounce");
    idle(3);
    drive(3'b000, 8'h77); idle(10);

    // A / B / op load sequence
    for (int k = 0; k < 3; k++) begin
      drive(a_btn[k], a_sw[k]);
      expect_press(a_btn[k], a_sw[k], "load");
      idle(2);
      drive(3'b000, 8'h00); idle(10);
    end

    // Simultaneous press
    drive(3'b011, 8'h55);
`ifdef BTN_ONEHOT_PULSE_EN
    expect_press(3'b001, 8'h55, "simul");
`else
    expect_press(3'b011, 8'h55, "simul");
`endif
    chk("simul_level", 32'(o_btn_level), 32'h3);
    drive(3'b000, 8'h00); idle(10);

    // Reset mid-debounce with button held
    drive(3'b001, 8'h9A);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clock); #2;
      chk("mid_rst_no_pulse", 32'(o_btn_pulse), 32'd0);
    end
    @(negedge clock); i_rst = 1'b1;
    @(negedge clock); i_rst = 1'b0;
    expect_press(3'b001, 8'h9A, "mid_rst");
    drive(3'b000, 8'h00); idle(10);

    // Randomized bouncing buttons and changing switches
    hold = '{default: 0};
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      for (int i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          i_btn[i] = 1'($urandom_range(1, 0));
          hold[i]  = $urandom_range(12, 1);
        end
        hold[i]--;
      end
      if ($urandom_range(3, 0) == 0) i_sw_data = 8'($urandom);
      i_rst = ($urandom_range(199, 0) == 0);
    end
    @(negedge clock); i_rst = 1'b0; i_btn = '0;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
